ram_io_responder: RTL and testbench
===================================

Name: ram_io_responder

Overview:
Responder end of the byte-serial memory bus driven by the CPU memory controller. It provides RAM storage with one-cycle registered read latency. It also decodes an IO window at 0x30000, which holds a TX byte FIFO toward the host/UART, a one-byte RX holding register, a status byte and a halt register. It sits at the top level, between mem_ctrl and the host-side IO link.

Parameters:
ADDR_WIDTH, 17, RAM size is 2**ADDR_WIDTH bytes; RAM index is mem_a[ADDR_WIDTH-1:0]
TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
mem_a  in  32  byte address from controller
mem_dout  in  8  write data from controller
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  registered read data to controller
io_buffer_full  out  1  TX FIFO full
tx_data  out  8  TX FIFO head byte
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  host accepts tx_data this cycle
rx_data  in  8  host input byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  RX holding register empty
halt  out  1  sticky end-of-program flag
halt_code  out  8  byte written to the halt register

Behaviour:
- Reset values: mem_din=0, tx_valid=0, io_buffer_full=0, rx_ready=1, halt=0, halt_code=0, overflow=0, FIFO pointers=0. RAM contents are not reset.
- Reset mid-operation: FIFO contents and the RX byte are discarded.
- Region decode: IO when mem_a[17:16]==2'b11; RAM otherwise. IO offset is mem_a[2:0].
- RAM write: when mem_wr=1, ram[idx] <= mem_dout at the clock edge.
- RAM read: when mem_wr=0, mem_din <= ram[idx]. Data is visible the cycle after the address is presented (latency 1).
- RAM read-during-write to the same address: mem_din <= old contents (read-first).
- First-access qualifier:
  - Register prev_a and prev_wr every cycle; reset forces a mismatch.
  - first = (mem_a!=prev_a) || (mem_wr!=prev_wr).
  - IO side effects fire only when first=1. The controller holds its last address while idle, so this prevents repeated pops and pushes.
- IO write, offset 0: if first, push mem_dout into the TX FIFO.
  - If the FIFO is full and no pop happens the same cycle, drop the byte and set sticky overflow.
  - Push while full with a simultaneous pop: the push is accepted and the count is unchanged.
- IO write, offset 4: if first and halt=0, set halt=1 and halt_code<=mem_dout. Later writes are ignored until reset.
- IO write, other offsets: ignored.
- IO read, offset 0: mem_din <= the RX byte if rx_full, else 0.
  - If first and rx_full, clear rx_full (pop).
  - A capture cannot coincide with a pop, because rx_ready=0 whenever rx_full=1.
- IO read, offset 4: mem_din <= {5'b0, overflow, rx_full, io_buffer_full}. No side effect.
- IO read, other offsets: mem_din <= 0. No side effect.
- RX capture: when rx_valid && rx_ready, latch rx_data and set rx_full. rx_ready = !rx_full.
- TX FIFO:
  - Read and write pointers are log2(TX_DEPTH)+1 bits wide; the extra bit is the wrap flag.
  - Empty when the pointers are equal; full when the low bits are equal and the wrap bits differ.
  - tx_data is the head entry (combinational read); tx_valid = !empty.
  - Pop on tx_valid && tx_ready.
  - Pointers wrap modulo 2*TX_DEPTH.
- io_buffer_full = full (combinational from the pointers).

Decomposition:
- Package ram_io_defs holds the shared constants:
  - IO_REGION tag (2'b11)
  - offsets OFS_DATA=0 and OFS_CTRL=4
  - status bit indices STAT_TXFULL=0, STAT_RXFULL=1, STAT_OVF=2
  - Read/Write encodings of mem_wr
- One sub-module, byte_fifo: synchronous FIFO with DEPTH parameter, push/pop/full/empty/head ports. It is instantiated once for TX.

Test Plan:
- RAM word: write 0x1000..0x1003 = 0xEF,0xBE,0xAD,0xDE, then read each address -> mem_din, one cycle later, is 0xEF,0xBE,0xAD,0xDE.
- Repeated-address read: rx_valid with rx_data=0x41; then hold mem_a=0x30000 read for 5 cycles -> mem_din=0x41 once, rx_full clears once; the status read at 0x30004 then returns 0x00.
- TX fill: tx_ready=0; alternately write 0x30000 (0x01..0x11) and 0x30001, giving 17 pushes -> io_buffer_full=1 after the 16th; status=0x05 (overflow + txfull); draining with tx_ready=1 yields 0x01..0x10 in order, then tx_valid=0.
- Push while full with pop: with the FIFO full, write 0x30000=0xAA in the same cycle as tx_ready=1 -> no overflow, count stays 16, 0xAA is the last byte drained.
- Halt: write 0x30004=0x07, then 0x30004=0x09 -> halt=1, halt_code=0x07.
- Reset mid-operation: 3 bytes queued and rx_full=1; pulse rst -> tx_valid=0, rx_ready=1, halt=0, mem_din=0; RAM byte 0x1000 still reads 0xEF.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the byte-serial memory responder: IO window tag, register offsets, status bits.
package ram_io_defs;

    // mem_a[17:16] value that selects the IO window
    localparam logic [1:0] IO_REGION = 2'b11;

    // IO register offsets (mem_a[2:0])
    localparam logic [2:0] OFS_DATA = 3'd0;
    localparam logic [2:0] OFS_CTRL = 3'd4;

    // Status byte bit positions
    localparam int unsigned STAT_TXFULL = 0;
    localparam int unsigned STAT_RXFULL = 1;
    localparam int unsigned STAT_OVF    = 2;

    // mem_wr encodings
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and a combinational head read.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer update; extra MSB is the wrap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage write, contents are not reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/ram_io_responder.sv
// Memory-bus responder: byte RAM with registered reads plus an IO window (TX FIFO, RX byte, status, halt).
module ram_io_responder
    import ram_io_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt,
    output logic [7:0]  halt_code
);

    logic [7:0]            ram_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_io;
    logic [2:0]            ofs;
    logic                  is_wr;

    logic [31:0] prev_a_q;
    logic        prev_wr_q;
    logic        prev_vld_q;
    logic        first;

    logic [7:0]  mem_din_q;
    logic        rx_full_q;
    logic [7:0]  rx_byte_q;
    logic        ovf_q;
    logic        halt_q;
    logic [7:0]  halt_code_q;

    logic        tx_push;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_pop;
    logic        rx_cap;
    logic [7:0]  status_c;

    assign idx   = mem_a[ADDR_WIDTH-1:0];
    assign is_io = (mem_a[17:16] == IO_REGION);
    assign ofs   = mem_a[2:0];
    assign is_wr = (mem_wr == MEM_WRITE);

    // The controller parks on its last address, so side effects fire only on a new access
    assign first = !prev_vld_q || (mem_a != prev_a_q) || (mem_wr != prev_wr_q);

    assign tx_push = first && is_io && is_wr && (ofs == OFS_DATA);
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_pop  = first && is_io && !is_wr && (ofs == OFS_DATA) && rx_full_q;
    assign rx_cap  = rx_valid && rx_ready;

    // Status byte assembly
    always_comb begin
        status_c              = '0;
        status_c[STAT_TXFULL] = tx_full;
        status_c[STAT_RXFULL] = rx_full_q;
        status_c[STAT_OVF]    = ovf_q;
    end

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .din_i   (mem_dout),
        .pop_i   (tx_pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_data)
    );

    // RAM storage write, contents survive reset
    always_ff @(posedge clk) begin
        if (!is_io && is_wr) ram_q[idx] <= mem_dout;
    end

    // Previous-access tracking; reset invalidates it so the next access is always first
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_a_q   <= '0;
            prev_wr_q  <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_a_q   <= mem_a;
            prev_wr_q  <= mem_wr;
            prev_vld_q <= 1'b1;
        end
    end

    // Registered read data: RAM read-first, IO registers by offset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din_q <= '0;
        end else if (!is_wr) begin
            if (!is_io) begin
                mem_din_q <= ram_q[idx];
            end else begin
                case (ofs)
                    OFS_DATA: mem_din_q <= rx_full_q ? rx_byte_q : 8'h00;
                    OFS_CTRL: mem_din_q <= status_c;
                    default:  mem_din_q <= 8'h00;
                endcase
            end
        end
    end

    // RX holding register; capture and pop never coincide since capture needs it empty
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full_q <= 1'b0;
            rx_byte_q <= '0;
        end else if (rx_cap) begin
            rx_full_q <= 1'b1;
            rx_byte_q <= rx_data;
        end else if (rx_pop) begin
            rx_full_q <= 1'b0;
        end
    end

    // Sticky overflow on a dropped TX byte, sticky halt with first code written
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q       <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            if (tx_push && tx_full && !tx_pop) ovf_q <= 1'b1;
            if (first && is_io && is_wr && (ofs == OFS_CTRL) && !halt_q) begin
                halt_q      <= 1'b1;
                halt_code_q <= mem_dout;
            end
        end
    end

    assign mem_din        = mem_din_q;
    assign io_buffer_full = tx_full;
    assign tx_valid       = !tx_empty;
    assign rx_ready       = !rx_full_q;
    assign halt           = halt_q;
    assign halt_code      = halt_code_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM, RX pop, TX FIFO fill/drain, halt and reset behaviour.
module tb_ram_io_responder;

    logic        clk;
    logic        rst;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;
    logic [7:0]  halt_code;

    int n_cmp;
    int n_err;

    ram_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .halt           (halt),
        .halt_code      (halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: present inputs, let the edge happen, settle just after it
    task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic wr);
        mem_a    = a;
        mem_dout = d;
        mem_wr   = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] ram_exp [4];

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        mem_a    = 32'h0;
        mem_dout = 8'h0;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h0;
        rx_valid = 1'b0;
        ram_exp[0] = 8'hEF;
        ram_exp[1] = 8'hBE;
        ram_exp[2] = 8'hAD;
        ram_exp[3] = 8'hDE;

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_full", 32'(io_buffer_full), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_halt_code", 32'(halt_code), 32'h0);

        // RAM bytes written then read back with one-cycle latency
        for (int i = 0; i < 4; i++) cyc(32'h1000 + 32'(i), ram_exp[i], 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(32'h1000 + 32'(i), 8'h00, 1'b0);
            chk($sformatf("ram_rd_%0d", i), 32'(mem_din), 32'(ram_exp[i]));
        end

        // RX capture, then a held read pops exactly once
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        cyc(32'h1000, 8'h00, 1'b0);
        rx_valid = 1'b0;
        chk("rx_captured", 32'(rx_ready), 32'h0);
        cyc(32'h30000, 8'h00, 1'b0);
        chk("rx_pop_data", 32'(mem_din), 32'h41);
        chk("rx_pop_ready", 32'(rx_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(32'h30000, 8'h00, 1'b0);
            chk($sformatf("rx_held_%0d", i), 32'(mem_din), 32'h0);
        end
        cyc(32'h30004, 8'h00, 1'b0);
        chk("rx_status", 32'(mem_din), 32'h00);

        // TX fill: 17 pushes into 16 entries, last one dropped
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            cyc(32'h30000, 8'(i), 1'b1);
            if (i == 15) chk("tx_full_at15", 32'(io_buffer_full), 32'h0);
            if (i == 16) chk("tx_full_at16", 32'(io_buffer_full), 32'h1);
            cyc(32'h30001, 8'h00, 1'b1);
        end
        cyc(32'h30004, 8'h00, 1'b0);
        chk("tx_ovf_status", 32'(mem_din), 32'h05);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("tx_drain_v%0d", i), 32'(tx_valid), 32'h1);
            chk($sformatf("tx_drain_d%0d", i), 32'(tx_data), 32'(i));
            cyc(32'h30004, 8'h00, 1'b0);
        end
        chk("tx_drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Push while full with a simultaneous pop
        pulse_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(32'h30000, 8'(8'h20 + 8'(i)), 1'b1);
            cyc(32'h30001, 8'h00, 1'b1);
        end
        chk("pf_full", 32'(io_buffer_full), 32'h1);
        tx_ready = 1'b1;
        cyc(32'h30000, 8'hAA, 1'b1);
        tx_ready = 1'b0;
        chk("pf_still_full", 32'(io_buffer_full), 32'h1);
        chk("pf_head", 32'(tx_data), 32'h22);
        cyc(32'h30004, 8'h00, 1'b0);
        chk("pf_status", 32'(mem_din), 32'h01);
        tx_ready = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("pf_drain_%0d", i), 32'(tx_data), 32'(8'h20 + 8'(i)));
            cyc(32'h30004, 8'h00, 1'b0);
        end
        chk("pf_last", 32'(tx_data), 32'hAA);
        cyc(32'h30004, 8'h00, 1'b0);
        chk("pf_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Halt is sticky and keeps the first code
        cyc(32'h30004, 8'h07, 1'b1);
        chk("halt_set", 32'(halt), 32'h1);
        cyc(32'h1000, 8'h00, 1'b0);
        cyc(32'h30004, 8'h09, 1'b1);
        chk("halt_sticky", 32'(halt), 32'h1);
        chk("halt_code", 32'(halt_code), 32'h07);

        // Reset mid-operation discards TX/RX state, keeps RAM
        for (int i = 0; i < 3; i++) begin
            cyc(32'h30000, 8'(8'h60 + 8'(i)), 1'b1);
            cyc(32'h30001, 8'h00, 1'b1);
        end
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        cyc(32'h1000, 8'h00, 1'b0);
        rx_valid = 1'b0;
        chk("mid_tx_valid", 32'(tx_valid), 32'h1);
        chk("mid_rx_ready", 32'(rx_ready), 32'h0);
        chk("mid_mem_din", 32'(mem_din), 32'hEF);
        rst = 1'b1;
        cyc(32'h1000, 8'h00, 1'b0);
        chk("mrst_tx_valid", 32'(tx_valid), 32'h0);
        chk("mrst_rx_ready", 32'(rx_ready), 32'h1);
        chk("mrst_halt", 32'(halt), 32'h0);
        chk("mrst_halt_code", 32'(halt_code), 32'h0);
        chk("mrst_mem_din", 32'(mem_din), 32'h0);
        rst = 1'b0;
        cyc(32'h1000, 8'h00, 1'b0);
        chk("mrst_ram_kept", 32'(mem_din), 32'hEF);
        cyc(32'h30004, 8'h00, 1'b0);
        chk("mrst_status", 32'(mem_din), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
